// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: same-cycle grants, tie-break by
// last winner, optional locked bursts capped at MAX_BURST while the other waits.
module mem_arbiter #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          rvalid0_q, rvalid1_q;
  logic          g0, g1;

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) g0 = 1'b1;
        else if (req1)                 g1 = 1'b1;
        if (g0 && lock0) begin
          state_d = OWN0;
          bcnt_d  = 4'd1;
        end else if (g1 && lock1) begin
          state_d = OWN1;
          bcnt_d  = 4'd1;
        end
      end
      OWN0: begin
        // Owner keeps the port unless it stops asking or its burst is used up
        // while the other side waits; the other side then takes this cycle.
        if (req0 && (!req1 || bcnt_q < MAXB)) g0 = 1'b1;
        else if (req1)                        g1 = 1'b1;
        if (g0 && lock0) begin
          if (bcnt_q < MAXB) bcnt_d = bcnt_q + 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (req1 && (!req0 || bcnt_q < MAXB)) g1 = 1'b1;
        else if (req0)                        g0 = 1'b1;
        if (g1 && lock1) begin
          if (bcnt_q < MAXB) bcnt_d = bcnt_q + 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (g0)      last_d = 1'b0;
    else if (g1) last_d = 1'b1;
    if (reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (g0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (g1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      bcnt_q    <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      rvalid0_q <= g0 && !we0;
      rvalid1_q <= g1 && !we1;
      if (g0 && !we0) rdata0_q <= mem_rdata;
      if (g1 && !we1) rdata1_q <= mem_rdata;
    end
  end

  assign gnt0    = g0;
  assign gnt1    = g1;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and random
// traffic, all checked against an ownership/burst reference model.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset, req0, we0, lock0, req1, we1, lock1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic [31:0] exp_mem [256];

  int errors = 0;
  int checks = 0;

  // Reference model state: owner -1 means nobody holds a lock.
  int          m_owner, m_cnt, m_last;
  bit          m_rv [2];
  logic [31:0] m_rd [2];

  typedef struct {
    bit rst, r0, r1, w0, w1, l0, l1;
    logic [31:0] a0, a1, d0, d1;
    bit eg0, eg1, ewe;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  mem_arbiter #(.DW(32), .AW(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rst, bit r0, bit r1, bit w0, bit w1, bit l0, bit l1,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] d0,
                              logic [31:0] d1, bit eg0, bit eg1, bit ewe);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe;
    return v;
  endfunction

  function automatic int model_grant(vec_t v);
    bit rq [2];
    int o;
    rq[0] = v.r0;
    rq[1] = v.r1;
    if (v.rst) return -1;
    if (m_owner < 0) begin
      if (rq[0] && rq[1]) return 1 - m_last;
      if (rq[0]) return 0;
      if (rq[1]) return 1;
      return -1;
    end
    o = m_owner;
    if (rq[o] && (!rq[1-o] || m_cnt < MAXB)) return o;
    if (rq[1-o]) return 1 - o;
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
  endfunction

  // Applies one cycle: drive, compare mid-cycle, clock, advance model and memory.
  task automatic step(input vec_t v, input bit use_exp);
    int g;
    bit we [2];
    bit lk [2];
    logic [31:0] ad [2];
    logic [31:0] dt [2];
    bit s_we;
    logic [31:0] s_addr, s_wdata;
    reset = v.rst; req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    lock0 = v.l0; lock1 = v.l1; addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    we[0] = v.w0; we[1] = v.w1; lk[0] = v.l0; lk[1] = v.l1;
    ad[0] = v.a0; ad[1] = v.a1; dt[0] = v.d0; dt[1] = v.d1;
    #2;
    g = model_grant(v);
    chk("gnt0", 64'(gnt0), 64'(g == 0));
    chk("gnt1", 64'(gnt1), 64'(g == 1));
    chk("mem_we", 64'(mem_we), 64'((g >= 0) ? we[g] : 1'b0));
    chk("mem_addr", 64'(mem_addr), 64'((g >= 0) ? ad[g] : 32'd0));
    chk("mem_wdata", 64'(mem_wdata), 64'((g >= 0) ? dt[g] : 32'd0));
    chk("rvalid0", 64'(rvalid0), 64'(m_rv[0]));
    chk("rvalid1", 64'(rvalid1), 64'(m_rv[1]));
    chk("rdata0", 64'(rdata0), 64'(m_rd[0]));
    chk("rdata1", 64'(rdata1), 64'(m_rd[1]));
    chk("gnt_mutex", 64'(gnt0 & gnt1), 64'd0);
    if (!gnt0 && !gnt1) chk("we_idle", 64'(mem_we), 64'd0);
    if (use_exp) begin
      chk("tbl_gnt0", 64'(gnt0), 64'(v.eg0));
      chk("tbl_gnt1", 64'(gnt1), 64'(v.eg1));
      chk("tbl_we", 64'(mem_we), 64'(v.ewe));
    end
    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge clk);
    #1;
    if (s_we) mem[s_addr[9:2]] = s_wdata;
    if (v.rst) begin
      model_reset();
    end else begin
      m_rv[0] = 0;
      m_rv[1] = 0;
      if (g >= 0) begin
        m_last = g;
        if (we[g]) exp_mem[ad[g][9:2]] = dt[g];
        else begin
          m_rd[g] = exp_mem[ad[g][9:2]];
          m_rv[g] = 1;
        end
      end
      if (m_owner < 0) begin
        if (g >= 0 && lk[g]) begin
          m_owner = g;
          m_cnt = 1;
        end
      end else if (g == m_owner && lk[g]) begin
        m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'(i * 7 + 3);
      exp_mem[i] = 32'(i * 7 + 3);
    end
    mem[21] = 32'd7;
    exp_mem[21] = 32'd7;
    model_reset();
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(posedge clk);
    #1;

    // Reset with both requesting, then alternating tie writes.
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 60, 80, 28, 7, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 60, 80, 28, 7, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 60, 80, 28, 7, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 60, 80, 28, 7, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 60, 80, 28, 7, 0, 1, 1));
    // Locked read burst by 0 against a waiting 1: four grants then handover.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 80, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 4, 80, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 8, 80, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 12, 80, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 16, 80, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i], 1);
    chk("mem60", 64'(mem[15]), 64'd28);
    chk("mem80", 64'(mem[20]), 64'd7);

    // Registered read data pulse and hold.
    step(mk(0, 1, 0, 0, 0, 0, 0, 84, 0, 0, 0, 1, 0, 0), 1);
    chk("rd_valid_pulse", 64'(rvalid0), 64'd1);
    chk("rd_data", 64'(rdata0), 64'd7);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    chk("rd_valid_drop", 64'(rvalid0), 64'd0);
    chk("rd_data_hold", 64'(rdata0), 64'd7);

    // Lone locked requester 1 saturates the burst count, then 0 cuts in.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    for (int i = 0; i < 10; i++)
      step(mk(0, 0, 1, 0, 1, 0, 1, 0, 200, 0, 32'(i), 0, 1, 1), 1);
    chk("bcnt_sat", 64'(dut.bcnt_q), 64'(MAXB));
    step(mk(0, 1, 1, 0, 1, 0, 1, 84, 200, 0, 55, 1, 0, 0), 1);

    // Reset in the middle of a locked write burst.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 1, 0, 1, 0, 1, 0, 120, 0, 5, 0, 1, 1), 1);
    step(mk(1, 0, 1, 0, 1, 0, 1, 0, 120, 0, 99, 0, 0, 0), 1);
    chk("no_reset_write", 64'(mem[30]), 64'd5);
    step(mk(0, 1, 1, 0, 0, 0, 0, 8, 12, 0, 0, 1, 0, 0), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(39) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
             32'($urandom_range(63) * 4), 32'($urandom_range(63) * 4),
             $urandom, $urandom, 0, 0, 0);
      step(v, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
